// File: rtl/alu_seq_pkg.sv
// Opcodes, FSM state encoding and the registered flag bundle shared by the sequential ALU.
package alu_seq_pkg;

  localparam int WIDTH_DEF = 24;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_MAX   = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd4;
  localparam logic [3:0] OP_EQUAL = 4'd5;
  localparam logic [3:0] OP_SUBSF = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Latency: WIDTH steps after start, done pulses the cycle after the last step.
// Backpressure: none; start is only issued while idle and the product holds until the next start.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     psum;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand <= a;
        acc   <= {{WIDTH{1'b0}}, b};
        cnt   <= CW'(WIDTH);
      end else if (cnt != '0) begin
        acc <= {psum, acc[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign busy    = (cnt != '0);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and an iterative multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: one result held until out_ready; in_ready follows out_ready while holding.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state, state_nxt;
  flags_t             flg_q, flg_c, flg_mul;
  logic [WIDTH-1:0]   res_c, bneg;
  logic [WIDTH:0]     sum_c, dif_c;
  logic [SHW-1:0]     shamt;
  logic               big_sh, zero_fixed, accept, is_mul;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (opcode == OP_MUL);
  assign accept = in_valid & in_ready;
  assign shamt  = b[SHW-1:0];
  assign big_sh = (b >= WIDTH'(WIDTH));

  always_comb begin
    res_c      = '0;
    flg_c      = '0;
    zero_fixed = 1'b0;
    sum_c      = {1'b0, a} + {1'b0, b};
    dif_c      = {1'b0, a} - {1'b0, b};
    bneg       = ~b + WIDTH'(1);
    case (opcode)
      OP_ADD: begin
        res_c     = sum_c[WIDTH-1:0];
        flg_c.carry = sum_c[WIDTH];
        flg_c.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBSF: begin
        res_c       = dif_c[WIDTH-1:0];
        flg_c.carry = dif_c[WIDTH];
        flg_c.ovf   = (a[WIDTH-1] == bneg[WIDTH-1]) && (dif_c[WIDTH-1] != a[WIDTH-1]);
        if (opcode == OP_SUBSF) begin
          zero_fixed = 1'b1;
          flg_c.zero = (a == b);
        end
      end
      OP_AND: res_c = a & b;
      OP_MAX: res_c = (a >= b) ? a : b;
      OP_CMP: begin
        zero_fixed = 1'b1;
        flg_c.zero = (a <= b);
      end
      OP_EQUAL: begin
        zero_fixed = 1'b1;
        flg_c.zero = (a == b);
      end
      OP_OR:  res_c = a | b;
      OP_SLL: res_c = big_sh ? '0 : (a << shamt);
      OP_SRL: res_c = big_sh ? '0 : (a >> shamt);
      OP_SRA: res_c = big_sh ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      OP_MUL: res_c = '0;
      default: begin
        zero_fixed    = 1'b1;
        flg_c.zero    = 1'b1;
        flg_c.illegal = 1'b1;
      end
    endcase
    if (!zero_fixed) flg_c.zero = (res_c == '0);
    flg_c.neg = res_c[WIDTH-1];
  end

  always_comb begin
    flg_mul       = '0;
    flg_mul.zero  = (mul_prod[WIDTH-1:0] == '0);
    flg_mul.carry = |mul_prod[2*WIDTH-1:WIDTH];
    flg_mul.neg   = mul_prod[WIDTH-1];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~mul_busy;
        if (in_valid && !mul_busy) state_nxt = is_mul ? S_MUL : S_HOLD;
      end
      S_MUL: if (mul_done) state_nxt = S_HOLD;
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = !in_valid ? S_IDLE : (is_mul ? S_MUL : S_HOLD);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      flg_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        result <= res_c;
        flg_q  <= flg_c;
      end else if (state == S_MUL && mul_done) begin
        result <= mul_prod[WIDTH-1:0];
        flg_q  <= flg_mul;
      end
    end
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept & is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign out_valid = (state == S_HOLD);
  assign zero      = flg_q.zero;
  assign carry     = flg_q.carry;
  assign ovf       = flg_q.ovf;
  assign neg       = flg_q.neg;
  assign illegal   = flg_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with hand-computed results and flags.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'd0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] result;
  logic        zero, carry, ovf, neg, illegal;
  logic [4:0]  flg_obs;

  int checks = 0;
  int errors = 0;

  assign flg_obs = {zero, carry, ovf, neg, illegal};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .neg       (neg),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one op and returns #1 after the edge that accepted it; inputs are then scrambled.
  task automatic send(input logic [3:0] op, input logic [23:0] aa, input logic [23:0] bb);
    int n = 0;
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("send_timeout", 48'(in_ready), 48'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = OP_SUB; a = 24'hA5A5A5; b = 24'h5A5A5A;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [23:0] va;
    logic [23:0] vb;
    logic [23:0] res;
    logic [4:0]  flg;   // {zero, carry, ovf, neg, illegal}
  } vec_t;

  vec_t vecs [17] = '{
    '{OP_ADD,   24'hFFFFFF, 24'h000001, 24'h000000, 5'b11000},
    '{OP_SUB,   24'h800000, 24'h000001, 24'h7FFFFF, 5'b00100},
    '{OP_CMP,   24'h000005, 24'h000005, 24'h000000, 5'b10000},
    '{OP_SRA,   24'h800000, 24'd30,     24'hFFFFFF, 5'b00010},
    '{OP_SLL,   24'h800000, 24'd30,     24'h000000, 5'b10000},
    '{4'd13,    24'h123456, 24'h654321, 24'h000000, 5'b10001},
    '{OP_SUB,   24'h000001, 24'h000002, 24'hFFFFFF, 5'b01010},
    '{OP_AND,   24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 5'b00010},
    '{OP_OR,    24'h000000, 24'h000000, 24'h000000, 5'b10000},
    '{OP_MAX,   24'h000123, 24'h800000, 24'h800000, 5'b00010},
    '{OP_EQUAL, 24'h000007, 24'h000008, 24'h000000, 5'b00000},
    '{OP_SUBSF, 24'h000009, 24'h000009, 24'h000000, 5'b10000},
    '{OP_SRL,   24'h800000, 24'd4,      24'h080000, 5'b00000},
    '{OP_ADD,   24'h7FFFFF, 24'h000001, 24'h800000, 5'b00110},
    '{OP_CMP,   24'h000006, 24'h000005, 24'h000000, 5'b00000},
    '{OP_SRL,   24'h123456, 24'd24,     24'h000000, 5'b10000},
    '{OP_SRA,   24'h400000, 24'd1,      24'h200000, 5'b00000}
  };

  initial begin
    int n;
    int nvld;
    logic rdy_low;
    logic stable;
    logic seen;

    #1;
    chk("rst_in_ready",  48'(in_ready),  48'(1));
    chk("rst_out_valid", 48'(out_valid), 48'(0));
    chk("rst_result",    48'(result),    48'(0));
    chk("rst_flags",     48'(flg_obs),   48'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].va, vecs[i].vb);
      chk($sformatf("vec%0d_valid", i), 48'(out_valid), 48'(1));
      chk($sformatf("vec%0d_result", i), 48'(result), 48'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 48'(flg_obs), 48'(vecs[i].flg));
      pop();
      chk($sformatf("vec%0d_popped", i), 48'(out_valid), 48'(0));
    end

    // MUL latency and in_ready during the iteration.
    send(OP_MUL, 24'h001000, 24'h001000);
    n = 0; rdy_low = 1'b1;
    while (!out_valid && n < 60) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk("mul_latency", 48'(n), 48'(25));
    chk("mul_rdy_low", 48'(rdy_low), 48'(1));
    chk("mul_result", 48'(result), 48'(0));
    chk("mul_flags", 48'(flg_obs), 48'(5'b11000));
    pop();

    send(OP_MUL, 24'h000123, 24'h000456);
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    chk("mul2_result", 48'(result), 48'(24'h04EDC2));
    chk("mul2_flags", 48'(flg_obs), 48'(5'b00000));
    pop();

    send(OP_MUL, 24'hFFFFFF, 24'hFFFFFF);
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    chk("mul3_result", 48'(result), 48'(24'h000001));
    chk("mul3_flags", 48'(flg_obs), 48'(5'b01000));
    pop();

    // Hold with the consumer stalled, then same-edge pop+accept and streaming.
    send(OP_ADD, 24'd1, 24'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 24'($urandom); b = 24'($urandom);
      @(posedge clk); #1;
      if (result !== 24'd2 || flg_obs !== 5'b0 || !out_valid || in_ready) stable = 1'b0;
    end
    chk("hold_stable", 48'(stable), 48'(1));

    opcode = OP_ADD; a = 24'd2; b = 24'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("same_edge_rdy", 48'(in_ready), 48'(1));
    @(posedge clk); #1;
    chk("same_edge_valid", 48'(out_valid), 48'(1));
    chk("same_edge_result", 48'(result), 48'(5));

    nvld = 0;
    for (int i = 0; i < 8; i++) begin
      a = 24'(i * 10); b = 24'(i + 1);
      @(posedge clk); #1;
      if (out_valid) nvld++;
      chk($sformatf("stream%0d_result", i), 48'(result), 48'(11 * i + 1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream_count", 48'(nvld), 48'(8));
    chk("stream_drain", 48'(out_valid), 48'(0));

    // Asynchronous reset in the middle of a multiply.
    send(OP_MUL, 24'd3, 24'd4);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 48'(out_valid), 48'(0));
    chk("arst_in_ready",  48'(in_ready),  48'(1));
    chk("arst_result",    48'(result),    48'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_stale", 48'(seen), 48'(0));

    send(OP_ADD, 24'd4, 24'd5);
    chk("post_rst_result", 48'(result), 48'(9));
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
